// File: rtl/ddr_wr.sv
// AXI4 write master: buffers up to BURST_LEN stream beats, then issues AW, W and B for each burst.
// Burst n is written to ctrl_baseaddr + n*ctrl_addroffset.
module ddr_wr #(
  parameter int unsigned BURST_LEN        = 64,
  parameter int unsigned M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH       = 32
) (
  input  logic                        axi_aclk,
  input  logic                        axi_areset,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  output logic [M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic [DATA_WIDTH-1:0]       m_axi_wdata,
  output logic [3:0]                  m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic                        m_axi_wlast,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic                        ctrl_start,
  input  logic [M_AXI_ADDR_WIDTH-1:0] ctrl_baseaddr,
  input  logic [M_AXI_ADDR_WIDTH-1:0] ctrl_addroffset,
  output logic                        stat_done,
  output logic                        stat_err,
  output logic [15:0]                 stat_bursts
);

  localparam int unsigned CW    = $clog2(BURST_LEN + 1);
  localparam int unsigned IW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned DEPTH = 1 << IW;

  typedef enum logic [2:0] {IDLE, FILL, AW, W, B, DONE} state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]       buf_mem [DEPTH];
  logic [CW-1:0]               cnt;
  logic [CW-1:0]               rd;
  logic [CW-1:0]               cnt_inc;
  logic [M_AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [M_AXI_ADDR_WIDTH-1:0] offset;
  logic                        last_flag;
  logic                        last_beat;

  assign cnt_inc   = cnt + CW'(1);
  assign last_beat = (rd == cnt - CW'(1));

  assign m_axi_awaddr  = cur_addr;
  assign m_axi_awlen   = (cnt == '0) ? '0 : 8'(cnt - CW'(1));
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wdata   = buf_mem[rd[IW-1:0]];
  assign m_axi_wlast   = (state == W) && last_beat;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) state <= IDLE;
    else            state <= state_next;
  end

  // Handshake outputs come from the state register only, never from the ready inputs.
  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    case (state)
      IDLE, DONE: if (ctrl_start) state_next = FILL;
      FILL: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && ((cnt_inc == CW'(BURST_LEN)) || s_axis_tlast)) state_next = AW;
      end
      AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_next = W;
      end
      W: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && last_beat) state_next = B;
      end
      B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = last_flag ? DONE : FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      cnt         <= '0;
      rd          <= '0;
      cur_addr    <= '0;
      offset      <= '0;
      last_flag   <= 1'b0;
      stat_done   <= 1'b0;
      stat_err    <= 1'b0;
      stat_bursts <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ctrl_start) begin
            cur_addr    <= ctrl_baseaddr;
            offset      <= ctrl_addroffset;
            cnt         <= '0;
            last_flag   <= 1'b0;
            stat_done   <= 1'b0;
            stat_err    <= 1'b0;
            stat_bursts <= '0;
          end
        end
        FILL: begin
          if (s_axis_tvalid) begin
            cnt <= cnt_inc;
            if (s_axis_tlast) last_flag <= 1'b1;
          end
        end
        AW: if (m_axi_awready) rd <= '0;
        W:  if (m_axi_wready) rd <= rd + CW'(1);
        B: begin
          if (m_axi_bvalid) begin
            stat_err    <= stat_err | (m_axi_bresp != 2'b00);
            stat_bursts <= stat_bursts + 16'd1;
            cur_addr    <= cur_addr + offset;
            cnt         <= '0;
            if (last_flag) stat_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (state == FILL && s_axis_tvalid) buf_mem[cnt[IW-1:0]] <= s_axis_tdata;
  end

endmodule

// File: tb/tb_ddr_wr.sv
// Directed bench for ddr_wr: drives the stream, acts as AXI slave, checks bursts against hand-derived values.
module tb_ddr_wr;

  localparam int BL = 64;

  logic        axi_aclk = 1'b0;
  logic        axi_areset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic        m_axi_wlast;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic        ctrl_start;
  logic [31:0] ctrl_baseaddr;
  logic [31:0] ctrl_addroffset;
  logic        stat_done;
  logic        stat_err;
  logic [15:0] stat_bursts;

  ddr_wr #(.BURST_LEN(BL), .M_AXI_ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wlast(m_axi_wlast), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .ctrl_start(ctrl_start), .ctrl_baseaddr(ctrl_baseaddr),
    .ctrl_addroffset(ctrl_addroffset), .stat_done(stat_done),
    .stat_err(stat_err), .stat_bursts(stat_bursts)
  );

  always #5 axi_aclk = ~axi_aclk;

  int tests = 0;
  int fails = 0;
  logic [31:0] words[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
  endtask

  task automatic start_pulse(input logic [31:0] base, input logic [31:0] off);
    @(negedge axi_aclk);
    ctrl_baseaddr   = base;
    ctrl_addroffset = off;
    ctrl_start      = 1'b1;
    @(negedge axi_aclk);
    ctrl_start = 1'b0;
    check("start_clr_done",   32'(stat_done),   0);
    check("start_clr_err",    32'(stat_err),    0);
    check("start_clr_bursts", 32'(stat_bursts), 0);
  endtask

  // Streams words[0..n-1]; err_burst selects which burst gets SLVERR (-1 for none).
  task automatic run_xfer(input int n, input logic [31:0] base, input logic [31:0] off,
                          input int aw_stall, input bit wrand, input int err_burst);
    int widx = 0;
    int beat = 0;
    int nb = 0;
    int aws = 0;
    int aw_wait = 0;
    int cyc = 0;
    int nbursts = (n + BL - 1) / BL;
    int rem;
    bit w_stalled = 0;
    bit expect_aw = 0;
    logic [31:0] hold_addr = '0;
    logic [31:0] hold_len = '0;
    logic [31:0] hold_wdata = '0;
    start_pulse(base, off);
    while (!stat_done && cyc < 3000) begin
      s_axis_tvalid = (widx < n);
      s_axis_tdata  = (widx < n) ? words[widx] : '0;
      s_axis_tlast  = (widx == n - 1);
      m_axi_awready = (aw_wait >= aw_stall);
      m_axi_wready  = wrand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_bvalid  = m_axi_bready;
      m_axi_bresp   = (nb == err_burst) ? 2'b10 : 2'b00;
      if (expect_aw) begin
        check("aw_latency", 32'(m_axi_awvalid), 1);
        expect_aw = 0;
      end
      if (m_axi_awvalid || m_axi_wvalid || m_axi_bready)
        check("tready_low", 32'(s_axis_tready), 0);
      if (m_axi_awvalid) begin
        if (aw_wait > 0) begin
          check("awaddr_hold", m_axi_awaddr, hold_addr);
          check("awlen_hold", 32'(m_axi_awlen), hold_len);
        end
        hold_addr = m_axi_awaddr;
        hold_len  = 32'(m_axi_awlen);
        if (m_axi_awready) begin
          rem = n - nb * BL;
          check("awaddr", m_axi_awaddr, base + 32'(nb) * off);
          check("awlen", 32'(m_axi_awlen), 32'(((rem < BL) ? rem : BL) - 1));
          aws++;
          aw_wait = 0;
        end else begin
          aw_wait++;
        end
      end
      if (m_axi_wvalid) begin
        if (w_stalled) check("wdata_hold", m_axi_wdata, hold_wdata);
        check("w_after_aw", 32'(aws), 32'(nb + 1));
        hold_wdata = m_axi_wdata;
        w_stalled  = !m_axi_wready;
        if (m_axi_wready) begin
          check("beat_in_range", 32'(beat < n), 1);
          check("wdata", m_axi_wdata, (beat < n) ? words[beat] : 32'hBAD0_BAD0);
          check("wlast", 32'(m_axi_wlast), 32'(((beat + 1) % BL == 0) || (beat + 1 == n)));
          beat++;
        end
      end
      if (m_axi_bready) nb++;
      if (s_axis_tready && s_axis_tvalid) begin
        expect_aw = ((widx + 1) % BL == 0) || (widx + 1 == n);
        widx++;
      end
      @(posedge axi_aclk);
      @(negedge axi_aclk);
      cyc++;
    end
    idle_inputs();
    check("done",        32'(stat_done),   1);
    check("bursts",      32'(stat_bursts), 32'(nbursts));
    check("aw_count",    32'(aws),         32'(nbursts));
    check("beats",       32'(beat),        32'(n));
    check("words_taken", 32'(widx),        32'(n));
    check("err",         32'(stat_err),    32'(err_burst >= 0 && err_burst < nbursts));
    check("tready_done", 32'(s_axis_tready), 0);
  endtask

  initial begin
    int idx;
    int cyc;
    axi_areset      = 1'b1;
    ctrl_start      = 1'b0;
    ctrl_baseaddr   = '0;
    ctrl_addroffset = '0;
    idle_inputs();
    #1;
    check("rst_awvalid", 32'(m_axi_awvalid), 0);
    check("rst_wvalid",  32'(m_axi_wvalid),  0);
    check("rst_wlast",   32'(m_axi_wlast),   0);
    check("rst_bready",  32'(m_axi_bready),  0);
    check("rst_tready",  32'(s_axis_tready), 0);
    check("rst_awaddr",  m_axi_awaddr, 0);
    check("rst_awlen",   32'(m_axi_awlen), 0);
    check("rst_stats",   {13'd0, stat_done, stat_err, 1'b0, stat_bursts}, 0);
    check("awsize",      32'(m_axi_awsize), 32'h2);
    check("awburst",     32'(m_axi_awburst), 32'h1);
    check("wstrb",       32'(m_axi_wstrb), 32'hF);
    repeat (3) @(negedge axi_aclk);
    axi_areset = 1'b0;

    // 128 words: two full bursts, tlast on the 128th beat gives no empty third burst
    words.delete();
    for (int i = 0; i < 128; i++) words.push_back(32'(i));
    run_xfer(128, 32'h1000, 32'h100, 0, 1'b0, -1);

    // 70 words: full burst then a 6-beat burst
    words.delete();
    for (int i = 0; i < 70; i++) words.push_back(32'(i));
    run_xfer(70, 32'h1000, 32'h100, 0, 1'b0, -1);

    // AW stalled 10 cycles per burst, W ready at random
    words.delete();
    for (int i = 0; i < 70; i++) words.push_back(32'h5A00_0000 + 32'(i));
    run_xfer(70, 32'h2000, 32'h100, 10, 1'b1, -1);

    // SLVERR on burst 0 of 2: transfer still completes, error stays set
    words.delete();
    for (int i = 0; i < 128; i++) words.push_back(32'hA000_0000 + 32'(i));
    run_xfer(128, 32'h4000, 32'h400, 0, 1'b0, 0);
    repeat (5) @(negedge axi_aclk);
    check("err_sticky",  32'(stat_err),  1);
    check("done_sticky", 32'(stat_done), 1);

    // single word; the start pulse clears the sticky error
    words.delete();
    words.push_back(32'hDEADBEEF);
    run_xfer(1, 32'h8000, 32'h100, 0, 1'b0, -1);

    // second burst address wraps past 2^32
    words.delete();
    for (int i = 0; i < 128; i++) words.push_back(32'hC000_0000 + 32'(i));
    run_xfer(128, 32'hFFFF_FF00, 32'h100, 0, 1'b0, -1);

    // reset during W of burst 1 after an erroring burst 0
    words.delete();
    for (int i = 0; i < 70; i++) words.push_back(32'h0100_0000 + 32'(i));
    start_pulse(32'h3000, 32'h100);
    idx = 0;
    cyc = 0;
    while (!(m_axi_wvalid && stat_bursts == 16'd1) && cyc < 400) begin
      s_axis_tvalid = (idx < 70);
      s_axis_tdata  = (idx < 70) ? words[idx] : '0;
      s_axis_tlast  = (idx == 69);
      m_axi_awready = 1'b1;
      m_axi_wready  = (stat_bursts == 16'd0);
      m_axi_bvalid  = m_axi_bready;
      m_axi_bresp   = 2'b10;
      if (s_axis_tready && s_axis_tvalid) idx++;
      @(posedge axi_aclk);
      @(negedge axi_aclk);
      cyc++;
    end
    idle_inputs();
    check("pre_rst_in_w",   32'(m_axi_wvalid), 1);
    check("pre_rst_bursts", 32'(stat_bursts), 1);
    check("pre_rst_err",    32'(stat_err), 1);
    #2 axi_areset = 1'b1;
    #1;
    check("arst_wvalid",  32'(m_axi_wvalid),  0);
    check("arst_awvalid", 32'(m_axi_awvalid), 0);
    check("arst_bready",  32'(m_axi_bready),  0);
    check("arst_wlast",   32'(m_axi_wlast),   0);
    check("arst_tready",  32'(s_axis_tready), 0);
    check("arst_done",    32'(stat_done),     0);
    check("arst_err",     32'(stat_err),      0);
    check("arst_bursts",  32'(stat_bursts),   0);
    check("arst_awaddr",  m_axi_awaddr, 0);
    check("arst_awlen",   32'(m_axi_awlen), 0);
    @(negedge axi_aclk);
    axi_areset = 1'b0;

    // recovery after reset
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back(32'h7700_0000 + 32'(i));
    run_xfer(3, 32'h9000, 32'h100, 0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
